// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory controller.
// Size codes, FSM state type, byte-strobe generation and load extension.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } dmem_state_e;

    // Offset bits that must be zero for a naturally aligned access of this size.
    function automatic logic [2:0] dmem_align_mask(input logic [1:0] size);
        logic [2:0] mask;
        case (size)
            SZ_BYTE: mask = 3'b000;
            SZ_HALF: mask = 3'b001;
            SZ_WORD: mask = 3'b011;
            default: mask = 3'b111;
        endcase
        return mask;
    endfunction

    // Strobes sized for the widest (64-bit) word; narrower callers truncate.
    function automatic logic [7:0] dmem_strobe(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            SZ_BYTE: base = 8'h01;
            SZ_HALF: base = 8'h03;
            SZ_WORD: base = 8'h0f;
            default: base = 8'hff;
        endcase
        return base << off;
    endfunction

    function automatic logic [63:0] dmem_extend(input logic [63:0] word, input logic [1:0] size,
                                                input logic [2:0] off, input logic sgn);
        logic [63:0] sh;
        logic [63:0] res;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_BYTE: res = {{56{sgn & sh[7]}}, sh[7:0]};
            SZ_HALF: res = {{48{sgn & sh[15]}}, sh[15:0]};
            SZ_WORD: res = {{32{sgn & sh[31]}}, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port RAM with per-byte write strobes, registered write-first read.
// Contents are preloaded at time zero (index pattern or zeros) and never reset.
module dmem_ram #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned INIT_INDEX = 1
) (
    input  logic                       clk,
    input  logic                       en,
    input  logic [DATA_W/8-1:0]        be,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata
);

    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] merged;

    initial begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] = (INIT_INDEX != 0) ? DATA_W'(i) : '0;
        end
    end

    // Read port sees the bytes being written in the same cycle.
    always_comb begin
        merged = mem[addr];
        for (int unsigned b = 0; b < NB; b++) begin
            if (be[b]) begin
                merged[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
            rdata <= merged;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Request/response data-memory controller: decode, range/size checks, FSM, load extension.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses instead of force-aligning them.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned INIT_INDEX = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int unsigned NB     = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(NB);
    localparam int unsigned RAM_AW = $clog2(DEPTH);
    localparam int unsigned IDX_W  = ADDR_W - OFF_W;

    dmem_state_e state_q;
    logic [2:0]  cnt_q;
    logic [1:0]  size_q;
    logic [2:0]  off_q;
    logic        signed_q;
    logic        ld_ok_q;
    logic        err_q;

    logic [IDX_W-1:0]  idx;
    logic [2:0]        off_raw;
    logic [2:0]        amask;
    logic [2:0]        off_eff;
    logic              range_err;
    logic              size_err;
    logic              mis_err;
    logic              acc_err;
    logic              accept;
    logic [7:0]        strb_all;
    logic              ram_en;
    logic [NB-1:0]     ram_be;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [63:0]       ext;

    always_comb begin
        idx       = req_addr[ADDR_W-1:OFF_W];
        off_raw   = 3'(req_addr[OFF_W-1:0]);
        amask     = dmem_align_mask(req_size);
        range_err = 32'(idx) >= DEPTH;
        size_err  = (DATA_W == 32) && (req_size == SZ_DWORD);
`ifdef DMEM_MISALIGN_TRAP_EN
        mis_err   = |(off_raw & amask);
        off_eff   = off_raw;
`else
        mis_err   = 1'b0;
        off_eff   = off_raw & ~amask;
`endif
        acc_err   = range_err | size_err | mis_err;
        accept    = req_valid && (state_q == StIdle);
        strb_all  = dmem_strobe(req_size, off_eff);
        // Faulted accesses never touch the array, so a bad store cannot alias into it.
        ram_en    = accept && !acc_err;
        ram_be    = (ram_en && req_we) ? NB'(strb_all) : '0;
        ram_wdata = req_wdata << {off_eff, 3'b000};
    end

    dmem_ram #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .INIT_INDEX (INIT_INDEX)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .be    (ram_be),
        .addr  (idx[RAM_AW-1:0]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 3'd0;
            size_q   <= SZ_BYTE;
            off_q    <= 3'd0;
            signed_q <= 1'b0;
            ld_ok_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        size_q   <= req_size;
                        off_q    <= off_eff;
                        signed_q <= req_signed;
                        err_q    <= acc_err;
                        ld_ok_q  <= !req_we && !acc_err;
                        if (LATENCY <= 1) begin
                            state_q <= StResp;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= 3'(LATENCY - 1);
                        end
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        state_q <= StIdle;
                        err_q   <= 1'b0;
                        ld_ok_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // RAM read data is held until the next accept, so the extended result stays stable in StResp.
    always_comb begin
        ext        = dmem_extend(64'(ram_rdata), size_q, off_q, signed_q);
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StResp);
        resp_err   = resp_valid && err_q;
        resp_rdata = (resp_valid && ld_ok_q) ? DATA_W'(ext) : '0;
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl (32-bit, 256 words, LATENCY = 3, index-initialised).
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DEPTH   = 256;
    localparam int unsigned ADDR_W  = 15;
    localparam int unsigned LATENCY = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .LATENCY    (LATENCY),
        .INIT_INDEX (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [ADDR_W-1:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [DATA_W-1:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
    endtask

    // Full transaction with resp_ready held high; lat counts edges from accept to resp_valid.
    task automatic xfer(input logic we, input logic [ADDR_W-1:0] addr, input logic [1:0] size,
                        input logic sgn, input logic [DATA_W-1:0] wdata,
                        output logic [DATA_W-1:0] rdata, output logic err, output int lat);
        int guard;
        @(negedge clk);
        drive(we, addr, size, sgn, wdata);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("req_ready_timeout", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!resp_valid) check("resp_timeout", resp_valid, 1);
        rdata = resp_rdata;
        err   = resp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic ld_chk(input string tag, input logic [ADDR_W-1:0] addr, input logic [1:0] size,
                          input logic sgn, input logic [DATA_W-1:0] exp_data, input logic exp_err);
        logic [DATA_W-1:0] d;
        logic              e;
        int                l;
        xfer(1'b0, addr, size, sgn, '0, d, e, l);
        check({tag, "_data"}, d, exp_data);
        check({tag, "_err"}, e, exp_err);
    endtask

    task automatic st_chk(input string tag, input logic [ADDR_W-1:0] addr, input logic [1:0] size,
                          input logic [DATA_W-1:0] wdata, input logic exp_err);
        logic [DATA_W-1:0] d;
        logic              e;
        int                l;
        xfer(1'b1, addr, size, 1'b0, wdata, d, e, l);
        check({tag, "_data"}, d, '0);
        check({tag, "_err"}, e, exp_err);
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        logic              e;
        int                lat;

        rst        = 1'b1;
        resp_ready = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_size   = SZ_BYTE;
        req_signed = 1'b0;
        req_wdata  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_err", resp_err, 0);

        xfer(1'b0, 15'h0010, SZ_WORD, 1'b0, '0, d, e, lat);
        check("ld_w10_data", d, 32'h0000_0004);
        check("ld_w10_err", e, 0);
        check("ld_w10_latency", lat, LATENCY);

        // Upper store-data bits must not leak into neighbouring lanes.
        st_chk("st_b21", 15'h0021, SZ_BYTE, 32'h1234_56ab, 1'b0);
        ld_chk("ld_bs21", 15'h0021, SZ_BYTE, 1'b1, 32'hffff_ffab, 1'b0);
        ld_chk("ld_bu21", 15'h0021, SZ_BYTE, 1'b0, 32'h0000_00ab, 1'b0);
        ld_chk("ld_w20", 15'h0020, SZ_WORD, 1'b0, 32'h0000_ab08, 1'b0);
        ld_chk("ld_hs20", 15'h0020, SZ_HALF, 1'b1, 32'hffff_ab08, 1'b0);
        ld_chk("ld_hu20", 15'h0020, SZ_HALF, 1'b0, 32'h0000_ab08, 1'b0);
        ld_chk("ld_w24", 15'h0024, SZ_WORD, 1'b0, 32'h0000_0009, 1'b0);

        st_chk("st_h2a", 15'h002a, SZ_HALF, 32'hffff_8001, 1'b0);
        ld_chk("ld_ws28", 15'h0028, SZ_WORD, 1'b1, 32'h8001_000a, 1'b0);
        ld_chk("ld_hs2a", 15'h002a, SZ_HALF, 1'b1, 32'hffff_8001, 1'b0);
        ld_chk("ld_hu2a", 15'h002a, SZ_HALF, 1'b0, 32'h0000_8001, 1'b0);

        ld_chk("ld_oor", 15'h0400, SZ_WORD, 1'b0, 32'h0, 1'b1);
        st_chk("st_oor", 15'h0400, SZ_WORD, 32'hdead_beef, 1'b1);
        ld_chk("ld_w0_after_oor", 15'h0000, SZ_WORD, 1'b0, 32'h0, 1'b0);
        ld_chk("ld_w3fc", 15'h03fc, SZ_WORD, 1'b0, 32'h0000_00ff, 1'b0);
        ld_chk("ld_dword", 15'h0000, SZ_DWORD, 1'b0, 32'h0, 1'b1);

        // Response held off for 5 cycles: no new accept, data stable.
        resp_ready = 1'b0;
        @(negedge clk);
        drive(1'b0, 15'h0020, SZ_WORD, 1'b0, '0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            check("hold_wait_req_ready", req_ready, 0);
            @(posedge clk);
            #1 lat++;
        end
        check("hold_latency", lat, LATENCY);
        for (int i = 0; i < 5; i++) begin
            check("hold_resp_valid", resp_valid, 1);
            check("hold_resp_rdata", resp_rdata, 32'h0000_ab08);
            check("hold_req_ready", req_ready, 0);
            @(posedge clk);
            #1;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_done_resp_valid", resp_valid, 0);
        check("hold_done_req_ready", req_ready, 1);

`ifdef DMEM_MISALIGN_TRAP_EN
        ld_chk("mis_h03", 15'h0003, SZ_HALF, 1'b0, 32'h0, 1'b1);
        ld_chk("mis_w13", 15'h0013, SZ_WORD, 1'b0, 32'h0, 1'b1);
        st_chk("mis_st_h0f", 15'h000f, SZ_HALF, 32'h0000_beef, 1'b1);
        ld_chk("mis_w0c", 15'h000c, SZ_WORD, 1'b0, 32'h0000_0003, 1'b0);
`else
        ld_chk("mis_h03", 15'h0003, SZ_HALF, 1'b0, 32'h0, 1'b0);
        ld_chk("mis_w13", 15'h0013, SZ_WORD, 1'b0, 32'h0000_0004, 1'b0);
        st_chk("mis_st_h0f", 15'h000f, SZ_HALF, 32'h0000_beef, 1'b0);
        ld_chk("mis_w0c", 15'h000c, SZ_WORD, 1'b0, 32'hbeef_0003, 1'b0);
`endif

        // Reset during WAIT: store stays committed, response is dropped.
        @(negedge clk);
        drive(1'b1, 15'h0008, SZ_WORD, 1'b0, 32'h1234_5678);
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_wait_req_ready", req_ready, 1);
        check("rst_wait_resp_err", resp_err, 0);
        @(posedge clk);
        #1;
        check("rst_wait_resp_valid", resp_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_wait_resp_valid_late", resp_valid, 0);
        ld_chk("ld_w08_after_rst", 15'h0008, SZ_WORD, 1'b0, 32'h1234_5678, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
